// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave terminating into a bank of 32-bit control registers with flat output bus and write pulses.
// Optional AXI_LITE_SLAVE_SLVERR_EN: out-of-range accesses get SLVERR instead of aliasing by index.
module axi_lite_slave_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 8
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  output logic [C_NUM_REGS-1:0]                    REG_WR
);

  localparam int AW        = C_S_AXI_ADDR_WIDTH;
  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W    = DW / 8;
  localparam int IDX_W     = $clog2(C_NUM_REGS);
  localparam int IDX_LSB   = 2;
  localparam int UPPER_LSB = IDX_LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  function automatic logic [IDX_W-1:0] addr_index(input logic [AW-1:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return ((a >> UPPER_LSB) == '0);
  endfunction

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      else         res[b*8 +: 8] = old_v[b*8 +: 8];
    end
    return res;
  endfunction

  wstate_t             wstate_r, wstate_s;
  rstate_t             rstate_r, rstate_s;
  logic                aw_done_r, aw_done_s, w_done_r, w_done_s;
  logic [AW-1:0]       awaddr_r;
  logic [DW-1:0]       wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                awready_r, awready_s, wready_r, wready_s;
  logic                bvalid_r, bvalid_s;
  logic [1:0]          bresp_r, bresp_s;
  logic [C_NUM_REGS-1:0] reg_wr_r, reg_wr_s;
  logic                arready_r, arready_s, rvalid_r, rvalid_s;
  logic [DW-1:0]       rdata_r, rdata_s;
  logic [1:0]          rresp_r, rresp_s;
  logic [DW-1:0]       regs_r [C_NUM_REGS];
  logic                wr_en_s;

  logic                aw_hs_s, w_hs_s, ar_hs_s, have_aw_s, have_w_s;
  logic [AW-1:0]       wr_addr_s;
  logic [DW-1:0]       wr_data_s;
  logic [STRB_W-1:0]   wr_strb_s;
  logic [IDX_W-1:0]    wr_idx_s, rd_idx_s;
  logic                unused_s;

  assign aw_hs_s   = S_AXI_AWVALID && awready_r;
  assign w_hs_s    = S_AXI_WVALID && wready_r;
  assign ar_hs_s   = S_AXI_ARVALID && arready_r;
  assign have_aw_s = aw_done_r || aw_hs_s;
  assign have_w_s  = w_done_r || w_hs_s;
  // A handshake completing this cycle is used directly so the update lands one cycle later.
  assign wr_addr_s = aw_done_r ? awaddr_r : S_AXI_AWADDR;
  assign wr_data_s = w_done_r ? wdata_r : S_AXI_WDATA;
  assign wr_strb_s = w_done_r ? wstrb_r : S_AXI_WSTRB;
  assign wr_idx_s  = addr_index(wr_addr_s);
  assign rd_idx_s  = addr_index(S_AXI_ARADDR);
  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, awaddr_r};

  // Write channel next-state and next-output decode.
  always_comb begin
    wstate_s  = wstate_r;
    aw_done_s = aw_done_r;
    w_done_s  = w_done_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    reg_wr_s  = '0;
    wr_en_s   = 1'b0;
    case (wstate_r)
      W_IDLE, W_WAIT: begin
        if (have_aw_s && have_w_s) begin
          wstate_s  = W_RESP;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b0;
          bvalid_s  = 1'b1;
`ifdef AXI_LITE_SLAVE_SLVERR_EN
          if (addr_in_range(wr_addr_s)) begin
            wr_en_s            = 1'b1;
            reg_wr_s[wr_idx_s] = 1'b1;
            bresp_s            = RESP_OKAY;
          end else begin
            wr_en_s = 1'b0;
            bresp_s = RESP_SLVERR;
          end
`else
          wr_en_s            = 1'b1;
          reg_wr_s[wr_idx_s] = 1'b1;
          bresp_s            = RESP_OKAY;
`endif
        end else if (have_aw_s || have_w_s) begin
          wstate_s  = W_WAIT;
          aw_done_s = have_aw_s;
          w_done_s  = have_w_s;
          awready_s = !have_aw_s;
          wready_s  = !have_w_s;
        end else begin
          wstate_s  = W_IDLE;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_s  = W_IDLE;
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          wstate_s  = W_RESP;
          bvalid_s  = 1'b1;
          awready_s = 1'b0;
          wready_s  = 1'b0;
        end
      end
      default: begin
        wstate_s  = W_IDLE;
        aw_done_s = 1'b0;
        w_done_s  = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // Read channel next-state and next-output decode; data sampled before any same-cycle write.
  always_comb begin
    rstate_s  = rstate_r;
    arready_s = arready_r;
    rvalid_s  = rvalid_r;
    rdata_s   = rdata_r;
    rresp_s   = rresp_r;
    case (rstate_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_s  = R_DATA;
          arready_s = 1'b0;
          rvalid_s  = 1'b1;
`ifdef AXI_LITE_SLAVE_SLVERR_EN
          if (addr_in_range(S_AXI_ARADDR)) begin
            rdata_s = regs_r[rd_idx_s];
            rresp_s = RESP_OKAY;
          end else begin
            rdata_s = '0;
            rresp_s = RESP_SLVERR;
          end
`else
          rdata_s = regs_r[rd_idx_s];
          rresp_s = RESP_OKAY;
`endif
        end else begin
          rstate_s  = R_IDLE;
          arready_s = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_s  = R_IDLE;
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
        end else begin
          rstate_s  = R_DATA;
          rvalid_s  = 1'b1;
          arready_s = 1'b0;
        end
      end
      default: begin
        rstate_s  = R_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
      end
    endcase
  end

  // Control state, handshake capture and registered channel outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wstate_r  <= W_IDLE;
      rstate_r  <= R_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      reg_wr_r  <= '0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= 2'b00;
    end else begin
      wstate_r  <= wstate_s;
      rstate_r  <= rstate_s;
      aw_done_r <= aw_done_s;
      w_done_r  <= w_done_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
      reg_wr_r  <= reg_wr_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rdata_r   <= rdata_s;
      rresp_r   <= rresp_s;
      if (aw_hs_s) awaddr_r <= S_AXI_AWADDR;
      if (w_hs_s) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
      end
    end
  end

  // Register bank with byte-lane write enables.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int k = 0; k < C_NUM_REGS; k++) regs_r[k] <= '0;
    end else if (wr_en_s) begin
      regs_r[wr_idx_s] <= merge_lanes(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < C_NUM_REGS; gk++) begin : g_reg_out
      assign REG_OUT[gk*DW +: DW] = regs_r[gk];
    end
  endgenerate

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign REG_WR        = reg_wr_r;

endmodule
